// File: rtl/fb_write_unit.sv
// Pixel write coalescer for a 3-channel framebuffer: gathers pixel writes into
// one 16-pixel word per channel and writes them back, doing a read-modify-write when only part of the word is set.
module fb_write_unit #(
  parameter int READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [6:0]  wr_line,
  input  logic [6:0]  wr_offset,
  input  logic [2:0]  wr_pixel,
  input  logic        flush,
  output logic        busy,
  output logic        wr_dropped,
  output logic [13:0] bram_address,
  output logic        bram_read_enable,
  output logic [1:0]  bram_write_enable,
  output logic [15:0] bram_wdata_r,
  output logic [15:0] bram_wdata_g,
  output logic [15:0] bram_wdata_b,
  input  logic [15:0] bram_rdata_r,
  input  logic [15:0] bram_rdata_g,
  input  logic [15:0] bram_rdata_b
);

  // state   | meaning
  // IDLE    | buffer empty, any write accepted
  // ACCUM   | buffer holds a tag, same-tag writes merge in
  // RD      | one-cycle read strobe at the buffered address
  // RD_WAIT | wait for read data, merge it under the mask
  // WRITE   | one-cycle write strobe with the merged words
  typedef enum logic [2:0] {IDLE, ACCUM, RD, RD_WAIT, WRITE} state_t;

  state_t      state, state_next;
  logic [9:0]  tag;
  logic [15:0] mask, data_r, data_g, data_b;
  logic [2:0]  wait_cnt;

  logic [9:0]  in_tag;
  logic        on_screen, accept, load, tag_miss;
  logic [15:0] in_bit, mask_next;

  assign in_tag    = {wr_line, wr_offset[6:4]};
  assign on_screen = (wr_line < 7'd96);
  assign in_bit    = 16'h0001 << wr_offset[3:0];
  assign tag_miss  = wr_valid && on_screen && (in_tag != tag);
  assign accept    = wr_valid && wr_ready;
  assign load      = accept && on_screen && ((state == IDLE) || (state == ACCUM));
  assign mask_next = load ? (mask | in_bit) : mask;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (load) begin
          if (flush) state_next = (mask_next == 16'hFFFF) ? WRITE : RD;
          else       state_next = ACCUM;
        end
      end
      ACCUM: begin
        if (flush || tag_miss) state_next = (mask_next == 16'hFFFF) ? WRITE : RD;
      end
      RD:      state_next = RD_WAIT;
      RD_WAIT: if (wait_cnt == 3'd0) state_next = WRITE;
      WRITE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    wr_ready          = (state == IDLE) || ((state == ACCUM) && !tag_miss);
    busy              = (state != IDLE);
    bram_read_enable  = (state == RD);
    bram_write_enable = (state == WRITE) ? 2'b11 : 2'b00;
    bram_address      = {tag, 4'b0000};
    bram_wdata_r      = (state == WRITE) ? data_r : 16'h0000;
    bram_wdata_g      = (state == WRITE) ? data_g : 16'h0000;
    bram_wdata_b      = (state == WRITE) ? data_b : 16'h0000;
  end

  // Read data is valid when wait_cnt hits 1; the extra RD_WAIT cycle registers the merge.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag        <= 10'd0;
      mask       <= 16'h0000;
      data_r     <= 16'h0000;
      data_g     <= 16'h0000;
      data_b     <= 16'h0000;
      wait_cnt   <= 3'd0;
      wr_dropped <= 1'b0;
    end else begin
      wr_dropped <= accept && !on_screen;
      if (load) begin
        if (state == IDLE) tag <= in_tag;
        mask                   <= mask_next;
        data_r[wr_offset[3:0]] <= wr_pixel[2];
        data_g[wr_offset[3:0]] <= wr_pixel[1];
        data_b[wr_offset[3:0]] <= wr_pixel[0];
      end
      case (state)
        RD: wait_cnt <= 3'(READ_LATENCY);
        RD_WAIT: begin
          if (wait_cnt != 3'd0) wait_cnt <= wait_cnt - 3'd1;
          if (wait_cnt == 3'd1) begin
            data_r <= (bram_rdata_r & ~mask) | (data_r & mask);
            data_g <= (bram_rdata_g & ~mask) | (data_g & mask);
            data_b <= (bram_rdata_b & ~mask) | (data_b & mask);
          end
        end
        WRITE: mask <= 16'h0000;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_write_unit.sv
// Self-checking bench for fb_write_unit: a BRAM model with exact read latency
// plus queues of expected BRAM reads/writes checked as strobes appear.
module tb_fb_write_unit;
  localparam int RL = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_valid, wr_ready, flush, busy, wr_dropped;
  logic [6:0]  wr_line, wr_offset;
  logic [2:0]  wr_pixel;
  logic [13:0] bram_address;
  logic        bram_read_enable;
  logic [1:0]  bram_write_enable;
  logic [15:0] bram_wdata_r, bram_wdata_g, bram_wdata_b;
  logic [15:0] bram_rdata_r, bram_rdata_g, bram_rdata_b;

  fb_write_unit #(.READ_LATENCY(RL)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_line(wr_line), .wr_offset(wr_offset), .wr_pixel(wr_pixel), .flush(flush),
    .busy(busy), .wr_dropped(wr_dropped), .bram_address(bram_address),
    .bram_read_enable(bram_read_enable), .bram_write_enable(bram_write_enable),
    .bram_wdata_r(bram_wdata_r), .bram_wdata_g(bram_wdata_g), .bram_wdata_b(bram_wdata_b),
    .bram_rdata_r(bram_rdata_r), .bram_rdata_g(bram_rdata_g), .bram_rdata_b(bram_rdata_b)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rd_count = 0, wr_count = 0;
  int last_rd_cyc = 0, last_wr_cyc = 0, acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // BRAM model: stored word is presented only in the cycle READ_LATENCY after the strobe
  logic [15:0] mem_r = 16'h0, mem_g = 16'h0, mem_b = 16'h0;
  logic [7:0]  rd_sr = 8'h0;
  always @(posedge clk) rd_sr <= {rd_sr[6:0], bram_read_enable === 1'b1};
  assign bram_rdata_r = rd_sr[RL-1] ? mem_r : 16'h5A5A;
  assign bram_rdata_g = rd_sr[RL-1] ? mem_g : 16'hA5A5;
  assign bram_rdata_b = rd_sr[RL-1] ? mem_b : 16'h3C3C;

  typedef struct {
    logic [13:0] addr;
    logic [15:0] r, g, b;
  } wr_exp_t;
  wr_exp_t     exp_wr_q[$];
  logic [13:0] exp_rd_q[$];

  always @(negedge clk) begin
    if (cyc > 0) begin
      if (bram_read_enable !== 1'b0) begin
        rd_count++;
        last_rd_cyc = cyc;
        n_checks++;
        if (exp_rd_q.size() == 0) begin
          n_fail++;
          $display("FAIL bram_read: unexpected read strobe=%b addr=%h, required no read", bram_read_enable, bram_address);
        end else begin
          logic [13:0] ea;
          ea = exp_rd_q.pop_front();
          if (bram_read_enable !== 1'b1 || bram_address !== ea) begin
            n_fail++;
            $display("FAIL bram_read: addr=%h strobe=%b, required addr=%h", bram_address, bram_read_enable, ea);
          end
        end
      end
      if (bram_write_enable !== 2'b00) begin
        wr_count++;
        last_wr_cyc = cyc;
        n_checks++;
        if (exp_wr_q.size() == 0) begin
          n_fail++;
          $display("FAIL bram_write: unexpected write we=%b addr=%h", bram_write_enable, bram_address);
        end else begin
          wr_exp_t e;
          e = exp_wr_q.pop_front();
          if (bram_write_enable !== 2'b11 || bram_address !== e.addr || bram_wdata_r !== e.r ||
              bram_wdata_g !== e.g || bram_wdata_b !== e.b) begin
            n_fail++;
            $display("FAIL bram_write: we=%b addr=%h r=%h g=%h b=%h, required we=11 addr=%h r=%h g=%h b=%h",
                     bram_write_enable, bram_address, bram_wdata_r, bram_wdata_g, bram_wdata_b,
                     e.addr, e.r, e.g, e.b);
          end
        end
      end
    end
  end

  task automatic push_wr(input logic [13:0] a, input logic [15:0] r, g, b);
    wr_exp_t e;
    e.addr = a; e.r = r; e.g = g; e.b = b;
    exp_wr_q.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic drive_write(input logic [6:0] l, o, input logic [2:0] p, input logic fl, output bit ok);
    wr_valid = 1'b1; wr_line = l; wr_offset = o; wr_pixel = p; flush = fl;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (wr_ready === 1'b1) begin
        ok = 1'b1;
        acc_cyc = cyc;
        @(posedge clk);
        break;
      end
      @(posedge clk);
      @(negedge clk);
    end
    @(negedge clk);
    wr_valid = 1'b0; flush = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL write_accept: line=%0d off=%0d never accepted, required accept", l, o);
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy === 1'b0) begin done = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s_idle: busy=%b after 40 cycles, required 0", name, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || wr_dropped !== 1'b0 || bram_read_enable !== 1'b0 || bram_write_enable !== 2'b00 ||
        bram_address !== 14'h0 || bram_wdata_r !== 16'h0 || bram_wdata_g !== 16'h0 || bram_wdata_b !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b drop=%b re=%b we=%b addr=%h wd=%h/%h/%h, required all zero",
               busy, wr_dropped, bram_read_enable, bram_write_enable, bram_address,
               bram_wdata_r, bram_wdata_g, bram_wdata_b);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: wr_ready=%b, required 1", wr_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_full_word();
    bit ok;
    int rd0 = rd_count;
    push_wr(14'h000, 16'hFFFF, 16'h0000, 16'hFFFF);
    for (int i = 0; i < 16; i++) drive_write(7'd0, 7'(i), 3'b101, 1'b0, ok);
    do_flush();
    n_checks++;
    if (bram_write_enable !== 2'b11) begin
      n_fail++;
      $display("FAIL full_word_latency: we=%b one cycle after flush, required 11", bram_write_enable);
    end
    wait_idle("full_word");
    n_checks++;
    if (rd_count != rd0) begin
      n_fail++;
      $display("FAIL full_word_noread: reads=%0d, required 0", rd_count - rd0);
    end
  endtask

  task automatic test_partial_rmw();
    bit ok;
    mem_r = 16'h0; mem_g = 16'h0; mem_b = 16'h0;
    exp_rd_q.push_back(14'h280);
    push_wr(14'h280, 16'h0000, 16'h0008, 16'h0000);
    drive_write(7'd5, 7'd3, 3'b010, 1'b0, ok);
    do_flush();
    wait_idle("partial_rmw");
    n_checks++;
    if (last_wr_cyc - last_rd_cyc != RL + 2) begin
      n_fail++;
      $display("FAIL rmw_turnaround: %0d cycles, required %0d", last_wr_cyc - last_rd_cyc, RL + 2);
    end
  endtask

  // Mask 0x8004; R: 7FFB|0004, G: 0000|0004, B: 0F0B|8000
  task automatic test_merge();
    bit ok;
    mem_r = 16'hFFFF; mem_g = 16'h0000; mem_b = 16'h0F0F;
    exp_rd_q.push_back(14'h3A0);
    push_wr(14'h3A0, 16'h7FFF, 16'h0004, 16'h8F0B);
    drive_write(7'd7, 7'h22, 3'b110, 1'b0, ok);
    drive_write(7'd7, 7'h2F, 3'b001, 1'b0, ok);
    do_flush();
    wait_idle("merge");
  endtask

  task automatic test_tag_change();
    bit ok;
    mem_r = 16'h0; mem_g = 16'h0; mem_b = 16'h0;
    exp_rd_q.push_back(14'h080);
    push_wr(14'h080, 16'h0001, 16'h0001, 16'h0001);
    drive_write(7'd1, 7'd0, 3'b111, 1'b0, ok);
    wr_valid = 1'b1; wr_line = 7'd1; wr_offset = 7'd16; wr_pixel = 3'b010;
    #1;
    n_checks++;
    if (wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL tag_change_stall: wr_ready=%b, required 0", wr_ready);
    end
    drive_write(7'd1, 7'd16, 3'b010, 1'b0, ok);
    n_checks++;
    if (acc_cyc != last_wr_cyc + 1) begin
      n_fail++;
      $display("FAIL tag_change_accept: accepted cycle %0d, required %0d", acc_cyc, last_wr_cyc + 1);
    end
    n_checks++;
    if (bram_address !== 14'h090) begin
      n_fail++;
      $display("FAIL tag_change_newtag: addr=%h, required 090", bram_address);
    end
    exp_rd_q.push_back(14'h090);
    push_wr(14'h090, 16'h0000, 16'h0001, 16'h0000);
    do_flush();
    wait_idle("tag_change");
  endtask

  task automatic test_offscreen();
    bit ok;
    int rd0 = rd_count, wr0 = wr_count;
    drive_write(7'd100, 7'd5, 3'b111, 1'b0, ok);
    n_checks++;
    if (wr_dropped !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL offscreen_pulse: dropped=%b busy=%b, required 1/0", wr_dropped, busy);
    end
    @(negedge clk);
    n_checks++;
    if (wr_dropped !== 1'b0 || busy !== 1'b0 || rd_count != rd0 || wr_count != wr0) begin
      n_fail++;
      $display("FAIL offscreen_after: dropped=%b busy=%b strobes=%0d, required 0/0/0",
               wr_dropped, busy, rd_count - rd0 + wr_count - wr0);
    end
  endtask

  task automatic test_flush_idle();
    int rd0 = rd_count, wr0 = wr_count;
    do_flush();
    repeat (5) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || rd_count != rd0 || wr_count != wr0) begin
      n_fail++;
      $display("FAIL flush_idle_noop: busy=%b strobes=%0d, required 0/0", busy, rd_count - rd0 + wr_count - wr0);
    end
  endtask

  task automatic test_flush_with_write();
    bit ok;
    mem_r = 16'hF000; mem_g = 16'hF000; mem_b = 16'hF000;
    exp_rd_q.push_back(14'h180);
    push_wr(14'h180, 16'hF003, 16'hF003, 16'hF003);
    drive_write(7'd3, 7'd0, 3'b111, 1'b0, ok);
    drive_write(7'd3, 7'd1, 3'b111, 1'b1, ok);
    wait_idle("flush_with_write");
  endtask

  task automatic test_overwrite();
    bit ok;
    mem_r = 16'h0; mem_g = 16'h0; mem_b = 16'h0;
    exp_rd_q.push_back(14'h100);
    push_wr(14'h100, 16'h0000, 16'h0000, 16'h0080);
    drive_write(7'd2, 7'd7, 3'b100, 1'b0, ok);
    drive_write(7'd2, 7'd7, 3'b001, 1'b0, ok);
    do_flush();
    wait_idle("overwrite");
  endtask

  task automatic test_reset_mid();
    bit ok;
    int wr0 = wr_count;
    exp_rd_q.push_back(14'h480);
    drive_write(7'd9, 7'd0, 3'b001, 1'b0, ok);
    do_flush();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_state: busy=%b wr_ready=%b, required 0/1", busy, wr_ready);
    end
    repeat (10) @(negedge clk);
    n_checks++;
    if (wr_count != wr0) begin
      n_fail++;
      $display("FAIL reset_mid_nowrite: writes=%0d, required 0", wr_count - wr0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; wr_valid = 1'b0; flush = 1'b0;
    wr_line = 7'd0; wr_offset = 7'd0; wr_pixel = 3'd0;
    @(negedge clk);
    test_reset();
    test_full_word();
    test_partial_rmw();
    test_merge();
    test_tag_change();
    test_offscreen();
    test_flush_idle();
    test_flush_with_write();
    test_overwrite();
    test_reset_mid();
    n_checks++;
    if (exp_rd_q.size() != 0 || exp_wr_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d reads and %0d writes outstanding, required 0/0",
               exp_rd_q.size(), exp_wr_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
